// File: rtl/snake_pkg.sv
// Shared encodings, playfield geometry and the fixed obstacle list for the snake game.
package snake_pkg;

  localparam int unsigned GRID_W     = 40;
  localparam int unsigned GRID_H     = 30;
  localparam int unsigned XW         = 6;
  localparam int unsigned YW         = 5;
  localparam int unsigned LW         = 7;
  localparam int unsigned SW         = 8;
  localparam int unsigned MAX_LEN    = 72;
  localparam int unsigned INIT_LEN   = 3;
  localparam int unsigned START_X    = 20;
  localparam int unsigned START_Y    = 15;
  localparam int unsigned NUM_BLOCKS = 4;

  typedef enum logic [1:0] {
    MSM_IDLE = 2'b00,
    MSM_PLAY = 2'b01,
    MSM_WIN  = 2'b10,
    MSM_FAIL = 2'b11
  } msm_state_e;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    S_WAIT   = 2'b00,
    S_SCAN   = 2'b01,
    S_COMMIT = 2'b10
  } scan_state_e;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
  } cell_t;

  // Obstacle cells, highest index first: (25,12) (5,24) (34,5) (5,5)
  localparam logic [NUM_BLOCKS-1:0][XW+YW-1:0] BLOCK_LIST = {
    6'd25, 5'd12,
    6'd5,  5'd24,
    6'd34, 5'd5,
    6'd5,  5'd5
  };

  // True when the cell coincides with any obstacle.
  function automatic logic is_block(input cell_t c);
    logic hit;
    hit = 1'b0;
    for (int unsigned b = 0; b < NUM_BLOCKS; b++) begin
      if (cell_t'(BLOCK_LIST[b]) == c) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/snake_body_store.sv
// Snake body coordinate list: seg[0] is the head, shifted toward the tail on each commit.
module snake_body_store
  import snake_pkg::*;
(
  input  logic          CLK,
  input  logic          RESET,
  input  logic          init_i,
  input  logic          shift_i,
  input  cell_t         new_head_i,
  input  logic [LW-1:0] rd_idx_i,
  output cell_t         rd_cell_c_o,
  output cell_t         head_o
);

  cell_t seg_q [MAX_LEN];

  // Initial horizontal body facing right, or shift in a new head.
  always_ff @(posedge CLK) begin
    if (RESET || init_i) begin
      for (int k = 0; k < int'(MAX_LEN); k++) seg_q[k] <= '0;
      for (int k = 0; k < int'(INIT_LEN); k++) begin
        seg_q[k] <= '{x: XW'(int'(START_X) - k), y: YW'(START_Y)};
      end
    end else if (shift_i) begin
      for (int k = 1; k < int'(MAX_LEN); k++) seg_q[k] <= seg_q[k-1];
      seg_q[0] <= new_head_i;
    end
  end

  // Scan read port; indices past the storage depth read as empty.
  assign rd_cell_c_o = (rd_idx_i < LW'(MAX_LEN)) ? seg_q[rd_idx_i] : '0;
  assign head_o      = seg_q[0];

endmodule

// File: rtl/snake_collision_scorer.sv
// Evaluates each move tick against walls, obstacles and the body, then commits the move and scores apples.
module snake_collision_scorer
  import snake_pkg::*;
(
  input  logic          CLK,
  input  logic          RESET,
  input  logic [1:0]    MSM_State,
  input  logic          MOVE_TICK,
  input  logic [1:0]    DIR,
  input  logic [XW-1:0] APPLE_X,
  input  logic [YW-1:0] APPLE_Y,
  output logic          Hit_wall_sig,
  output logic          Hit_body_sig,
  output logic          Hit_block_sig,
  output logic [SW-1:0] SCORE,
  output logic          APPLE_EATEN,
  output logic [XW-1:0] HEAD_X,
  output logic [YW-1:0] HEAD_Y,
  output logic [LW-1:0] LENGTH,
  output logic          BUSY
);

  scan_state_e   state_q, state_d;
  cell_t         next_q, next_d;
  logic          grow_q, grow_d;
  logic [LW-1:0] idx_q, idx_d;
  logic [LW-1:0] len_q, len_d;
  logic [SW-1:0] score_q, score_d;
  logic          hit_wall_q, hit_wall_d;
  logic          hit_body_q, hit_body_d;
  logic          hit_block_q, hit_block_d;
  logic          eaten_q, eaten_d;
  logic          busy_q, busy_d;

  logic          init_c;
  logic          play_c;
  logic          shift_c;
  logic          wall_c;
  cell_t         cand_c;
  cell_t         apple_c;
  cell_t         head_c;
  cell_t         rd_cell_c;
  logic [LW-1:0] scan_lim_c;

  assign init_c  = (MSM_State == MSM_IDLE);
  assign play_c  = (MSM_State == MSM_PLAY);
  assign apple_c = '{x: APPLE_X, y: APPLE_Y};

  snake_body_store u_body (
    .CLK         (CLK),
    .RESET       (RESET),
    .init_i      (init_c),
    .shift_i     (shift_c),
    .new_head_i  (next_q),
    .rd_idx_i    (idx_q),
    .rd_cell_c_o (rd_cell_c),
    .head_o      (head_c)
  );

  // Candidate head for the current direction and whether it leaves the playfield.
  always_comb begin
    cand_c = head_c;
    wall_c = 1'b0;
    case (DIR)
      DIR_UP: begin
        wall_c   = (head_c.y == '0);
        cand_c.y = head_c.y - YW'(1);
      end
      DIR_DOWN: begin
        wall_c   = (head_c.y == YW'(GRID_H - 1));
        cand_c.y = head_c.y + YW'(1);
      end
      DIR_LEFT: begin
        wall_c   = (head_c.x == '0);
        cand_c.x = head_c.x - XW'(1);
      end
      default: begin
        wall_c   = (head_c.x == XW'(GRID_W - 1));
        cand_c.x = head_c.x + XW'(1);
      end
    endcase
  end

  // Without growth the tail vacates, so its cell is excluded from the scan.
  assign scan_lim_c = grow_q ? (len_q - LW'(1)) : (len_q - LW'(2));

  // Next-state and datapath updates for wait/scan/commit.
  always_comb begin
    state_d     = state_q;
    next_d      = next_q;
    grow_d      = grow_q;
    idx_d       = idx_q;
    len_d       = len_q;
    score_d     = score_q;
    hit_wall_d  = hit_wall_q;
    hit_body_d  = hit_body_q;
    hit_block_d = hit_block_q;
    eaten_d     = 1'b0;
    shift_c     = 1'b0;

    case (state_q)
      S_WAIT: begin
        // A game with a collision already recorded accepts no further moves.
        if (MOVE_TICK && play_c && !(hit_wall_q || hit_body_q || hit_block_q)) begin
          if (wall_c) begin
            hit_wall_d = 1'b1;
          end else if (is_block(cand_c)) begin
            hit_block_d = 1'b1;
          end else begin
            next_d  = cand_c;
            grow_d  = (cand_c == apple_c);
            idx_d   = '0;
            state_d = S_SCAN;
          end
        end
      end
      S_SCAN: begin
        if (rd_cell_c == next_q) begin
          hit_body_d = 1'b1;
          state_d    = S_WAIT;
        end else if (idx_q == scan_lim_c) begin
          state_d = S_COMMIT;
        end else begin
          idx_d = idx_q + LW'(1);
        end
      end
      S_COMMIT: begin
        state_d = S_WAIT;
        if (play_c) begin
          shift_c = 1'b1;
          if (grow_q) begin
            len_d   = (len_q == LW'(MAX_LEN)) ? len_q : len_q + LW'(1);
            score_d = (score_q == '1) ? score_q : score_q + SW'(1);
            eaten_d = 1'b1;
          end
        end
      end
      default: state_d = S_WAIT;
    endcase

    busy_d = (state_d != S_WAIT);
  end

  // State and datapath registers; IDLE behaves like reset.
  always_ff @(posedge CLK) begin
    if (RESET || init_c) begin
      state_q     <= S_WAIT;
      next_q      <= '0;
      grow_q      <= 1'b0;
      idx_q       <= '0;
      len_q       <= LW'(INIT_LEN);
      score_q     <= '0;
      hit_wall_q  <= 1'b0;
      hit_body_q  <= 1'b0;
      hit_block_q <= 1'b0;
      eaten_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      next_q      <= next_d;
      grow_q      <= grow_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      score_q     <= score_d;
      hit_wall_q  <= hit_wall_d;
      hit_body_q  <= hit_body_d;
      hit_block_q <= hit_block_d;
      eaten_q     <= eaten_d;
      busy_q      <= busy_d;
    end
  end

  assign Hit_wall_sig  = hit_wall_q;
  assign Hit_body_sig  = hit_body_q;
  assign Hit_block_sig = hit_block_q;
  assign SCORE         = score_q;
  assign APPLE_EATEN   = eaten_q;
  assign HEAD_X        = head_c.x;
  assign HEAD_Y        = head_c.y;
  assign LENGTH        = len_q;
  assign BUSY          = busy_q;

endmodule
